// File: rtl/mtr_duty_if.sv
// Command/status bundle between the motor controller and the duty stage.
// master drives commands and current sense; slave returns the duty word.
interface mtr_duty_if;
   logic [10:0] cmd;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic        ovr_I;
   logic        clr_fault;
   logic [10:0] duty;
   logic        duty_upd;
   logic        fault;

   modport master (
      output cmd, cmd_vld, ovr_I, clr_fault,
      input  cmd_rdy, duty, duty_upd, fault
   );

   modport slave (
      input  cmd, cmd_vld, ovr_I, clr_fault,
      output cmd_rdy, duty, duty_upd, fault
   );
endinterface

// File: rtl/mtr_duty_ctrl.sv
// Signed drive command to slew-limited PWM duty word,
// with blanked over-current monitor and latched fault.
module mtr_duty_ctrl #(
   parameter int SLEW_STEP = 4,
   parameter int BLANK     = 64,
   parameter int OVR_LIMIT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   mtr_duty_if.slave  bus
);

   typedef enum logic {NORM, FAULT} state_t;

   localparam logic [11:0] STEP = 12'(SLEW_STEP);
   localparam logic [11:0] BLK  = 12'(BLANK);
   localparam logic [7:0]  LIM  = 8'(OVR_LIMIT);
   localparam logic [10:0] MID  = 11'h400;

   state_t      state;
   logic [10:0] cnt;
   logic [10:0] target;
   logic [10:0] duty_r;
   logic [7:0]  ovr_cnt;
   logic        ovr_seen;
   logic        upd_r;
   logic        fault_r;

   logic        bnd;
   logic        xfer;
   logic        in_win;
   logic        ovr_now;
   logic        hit;
   logic [7:0]  ovr_nxt;
   logic        trip;
   logic [11:0] d12;
   logic [11:0] t12;
   logic [11:0] up;
   logic [11:0] dn;
   logic [10:0] slew_d;

   assign bnd     = (cnt == 11'd2047);
   assign xfer    = bus.cmd_vld && (state == NORM);
   assign in_win  = ({1'b0, cnt} >= BLK) && (cnt <= duty_r);
   assign ovr_now = in_win && bus.ovr_I;
   assign hit     = ovr_seen || ovr_now;

   always_comb begin
      ovr_nxt = 8'd0;
      if (hit)
         ovr_nxt = (ovr_cnt >= LIM) ? LIM : ovr_cnt + 8'd1;
   end

   assign trip = bnd && (state == NORM) && (ovr_nxt == LIM);

   // 12-bit math so the step can neither overshoot nor wrap
   always_comb begin
      d12    = {1'b0, duty_r};
      t12    = {1'b0, target};
      up     = t12 - d12;
      dn     = d12 - t12;
      slew_d = duty_r;
      unique case (1'b1)
         (t12 > d12): slew_d = 11'(d12 + ((up < STEP) ? up : STEP));
         (t12 < d12): slew_d = 11'(d12 - ((dn < STEP) ? dn : STEP));
         default:     slew_d = duty_r;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= NORM;
         cnt      <= 11'd0;
         target   <= MID;
         duty_r   <= MID;
         ovr_cnt  <= 8'd0;
         ovr_seen <= 1'b0;
         upd_r    <= 1'b0;
         fault_r  <= 1'b0;
      end else begin
         cnt   <= cnt + 11'd1;
         upd_r <= 1'b0;
         unique case (state)
            NORM: begin
               if (xfer)
                  target <= {~bus.cmd[10], bus.cmd[9:0]};
               if (bnd) begin
                  ovr_seen <= 1'b0;
                  if (trip) begin
                     state   <= FAULT;
                     fault_r <= 1'b1;
                     target  <= MID;
                     duty_r  <= MID;
                     upd_r   <= (duty_r != MID);
                     ovr_cnt <= 8'd0;
                  end else begin
                     ovr_cnt <= ovr_nxt;
                     duty_r  <= slew_d;
                     upd_r   <= (slew_d != duty_r);
                  end
               end else if (ovr_now) begin
                  ovr_seen <= 1'b1;
               end
            end
            FAULT: begin
               if (bus.clr_fault) begin
                  state    <= NORM;
                  fault_r  <= 1'b0;
                  ovr_cnt  <= 8'd0;
                  ovr_seen <= 1'b0;
               end
            end
            default: state <= NORM;
         endcase
      end
   end

   assign bus.cmd_rdy  = (state == NORM);
   assign bus.duty     = duty_r;
   assign bus.duty_upd = upd_r;
   assign bus.fault    = fault_r;

endmodule

// File: tb/tb_mtr_duty_ctrl.sv
// Directed/random bench for mtr_duty_ctrl against a
// period-level reference model.
module tb_mtr_duty_ctrl;

   localparam int S   = 300;
   localparam int B   = 64;
   localparam int L   = 3;
   localparam int MID = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mtr_duty_if bus ();

   mtr_duty_ctrl #(
      .SLEW_STEP (S),
      .BLANK     (B),
      .OVR_LIMIT (L)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int ncmp = 0;
   int nerr = 0;
   int ph;
   int m_duty;
   int m_target;
   int m_run;
   bit m_fault;
   bit m_upd;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      ph = (ph + 1) % 2048;
      #1;
   endtask

   // One PWM period, ending just after the boundary edge.
   // cpos/opos/clrpos: counter value of the event, -1 for none.
   task automatic period(input int cpos, input int c,
                         input int opos, input int clrpos);
      bit hit = 0;
      bit bx = 0;
      bit was_b;
      bit st;
      int bval = 0;
      int old;
      int d;
      do begin
         st = m_fault;
         bus.cmd_vld   = (ph == cpos);
         bus.cmd       = 11'(c);
         bus.ovr_I     = (ph == opos);
         bus.clr_fault = (ph == clrpos);
         if (ph == opos && !st && ph >= B && ph <= m_duty)
            hit = 1;
         if (ph == cpos) begin
            chk("cmd_rdy@cmd", bus.cmd_rdy, !st);
            if (!st) begin
               if (ph == 2047) begin
                  bx = 1;
                  bval = c + MID;
               end else begin
                  m_target = c + MID;
               end
            end
         end
         if (ph == 2047) begin
            m_upd = 0;
            if (!st) begin
               m_run = hit ? ((m_run + 1 > L) ? L : m_run + 1) : 0;
               old = m_duty;
               if (m_run == L) begin
                  m_fault  = 1;
                  m_duty   = MID;
                  m_target = MID;
                  m_run    = 0;
               end else begin
                  d = m_target - m_duty;
                  if (d > S)  d = S;
                  if (d < -S) d = -S;
                  m_duty = m_duty + d;
                  if (bx) m_target = bval;
               end
               m_upd = (m_duty != old);
            end
         end
         if (ph == clrpos && st) begin
            m_fault = 0;
            m_run   = 0;
         end
         was_b = (ph == 2047);
         tick;
         if (ph == 1)
            chk("upd_one_cycle", bus.duty_upd, 0);
      end while (!was_b);
      bus.cmd_vld   = 1'b0;
      bus.ovr_I     = 1'b0;
      bus.clr_fault = 1'b0;
      chk("duty", bus.duty, m_duty);
      chk("duty_upd", bus.duty_upd, m_upd);
      chk("fault", bus.fault, m_fault);
      chk("cmd_rdy", bus.cmd_rdy, !m_fault);
   endtask

   initial begin
      bus.cmd       = '0;
      bus.cmd_vld   = 1'b0;
      bus.ovr_I     = 1'b0;
      bus.clr_fault = 1'b0;
      ph       = 0;
      m_duty   = MID;
      m_target = MID;
      m_run    = 0;
      m_fault  = 0;
      m_upd    = 0;

      #12;
      chk("rst_duty", bus.duty, MID);
      chk("rst_upd", bus.duty_upd, 0);
      chk("rst_fault", bus.fault, 0);
      chk("rst_rdy", bus.cmd_rdy, 1);
      @(negedge clk);
      rst_n = 1'b1;
      ph = 0;

      // idle, then small command clamped by distance
      repeat (2) period(-1, 0, -1, -1);
      period($urandom_range(0, 2046), 100, -1, -1);
      // transfer in the boundary cycle uses the old target
      period(2047, -1024, -1, -1);
      repeat (5) period(-1, 0, -1, -1);
      period($urandom_range(0, 2046), 1023, -1, -1);
      repeat (7) period(-1, 0, -1, -1);

      // settle at 0x600, blanked over-current is ignored
      period($urandom_range(0, 2046), 512, -1, -1);
      period(-1, 0, -1, -1);
      repeat (2) period(-1, 0, $urandom_range(0, B - 1), -1);
      // persistent over-current trips; clear in trip cycle loses
      repeat (L - 1) period(-1, 0, 200, -1);
      period(-1, 0, 200, 2047);

      // in fault: command refused, then clear
      period($urandom_range(0, 2046), 300,
             $urandom_range(B, 1024), -1);
      period(-1, 0, -1, $urandom_range(0, 100));

      // a clean period breaks the run
      repeat (L - 1) period(-1, 0, $urandom_range(B, 1024), -1);
      period(-1, 0, -1, -1);
      repeat (L - 1) period(-1, 0, $urandom_range(B, 1024), -1);

      // random mix
      repeat (6) begin
         period(($urandom_range(0, 1) == 1) ?
                   $urandom_range(0, 2047) : -1,
                $urandom_range(0, 2047) - 1024,
                ($urandom_range(0, 3) != 0) ?
                   $urandom_range(0, 2047) : -1,
                $urandom_range(0, 2047));
      end

      // asynchronous reset mid-ramp
      period(-1, 0, -1, 5);
      period($urandom_range(0, 2046), 1023, -1, -1);
      repeat (500) tick;
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_duty", bus.duty, MID);
      chk("midrst_upd", bus.duty_upd, 0);
      chk("midrst_fault", bus.fault, 0);
      chk("midrst_rdy", bus.cmd_rdy, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/mtr_duty_ctrl.md
Name: mtr_duty_ctrl

Overview:
Upstream stage for the 11-bit PWM generator. It converts a signed drive command into the unsigned duty word that the PWM consumes. Duty updates only at PWM period boundaries and are slew-rate limited. Over-current is monitored inside a blanked on-time window, and persistent over-current latches a fault that forces zero drive (mid-scale duty) until software clears it.

Parameters:
SLEW_STEP, 4, maximum duty change (LSBs) applied per PWM period; legal range 1..1023
BLANK, 64, clocks after period start during which ovr_I is ignored (switching noise)
OVR_LIMIT, 8, consecutive over-current periods that trip the fault; legal range 1..255

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd  input  11  signed drive command, -1024..+1023
cmd_vld  input  1  cmd valid
cmd_rdy  output  1  block can accept cmd
ovr_I  input  1  over-current comparator, already synchronised
clr_fault  input  1  single-cycle fault clear request
duty  output  11  unsigned duty to PWM (count <= duty drives high)
duty_upd  output  1  one-cycle pulse when duty changes
fault  output  1  over-current fault latched

Behaviour:
- Reset values: duty=11'h400, duty_upd=0, fault=0, cmd_rdy=1. Internal state resets to: period counter 0, target 11'h400, ovr_cnt 0, ovr_seen 0, state NORM.
- Period counter: 11-bit free-running counter, +1 every clk, wraps 2047->0. Reset is shared with the PWM, so this counter runs in lockstep with it. A "boundary" is the cycle where the counter equals 2047.
- Command handshake: cmd_rdy = (state==NORM). A transfer occurs when cmd_vld && cmd_rdy. On transfer, target <= {~cmd[10], cmd[9:0]} (cmd + 0x400). There is no latency restriction, and a new transfer overwrites the previous target.
- Slew: at a boundary in NORM:
  - if target > duty: duty <= duty + min(SLEW_STEP, target - duty);
  - if target < duty: duty <= duty - min(SLEW_STEP, duty - target);
  - the step never overshoots and never wraps (arithmetic is 12-bit internally).
  - duty_upd is registered and pulses high in the cycle after the boundary, exactly when the new duty is visible, and only if duty actually changed.
- A transfer in the boundary cycle itself is not used by that boundary's slew step. The slew step uses the old target.
- Over-current sample window: counter >= BLANK and counter <= duty (PWM on-phase). If duty < BLANK, the window is empty.
  - ovr_seen is set if ovr_I=1 in the window. It is cleared at each boundary.
  - At a boundary: if ovr_seen (including a sample in the boundary cycle), ovr_cnt <= ovr_cnt + 1, saturating at OVR_LIMIT; otherwise ovr_cnt <= 0.
- State machine:
  - NORM -> FAULT when ovr_cnt reaches OVR_LIMIT (the boundary update makes it equal). In the same cycle: duty <= 11'h400 immediately, bypassing slew; target <= 11'h400; fault <= 1; duty_upd pulses if duty changed.
  - FAULT: cmd_rdy=0, duty held at 11'h400, ovr_I ignored, ovr_cnt held at 0.
  - FAULT -> NORM on clr_fault=1 (next cycle): fault <= 0, ovr_cnt and ovr_seen cleared, duty stays 11'h400, slewing resumes from 11'h400 on the next boundary.
  - clr_fault in NORM is ignored.
- Simultaneous events:
  - Fault trip and cmd transfer in the same cycle: the fault wins, target=11'h400.
  - clr_fault asserted in the trip cycle: the trip wins, and clr_fault must be reasserted.
- Reset mid-operation: every register returns to its reset value asynchronously, and duty returns to 11'h400 without slewing.

Test Plan:
- Reset, then hold cmd_vld=0 for 3 periods -> duty=11'h400, duty_upd never pulses, cmd_rdy=1, fault=0.
- Transfer cmd=+100 (SLEW_STEP=4) -> duty ramps 0x404, 0x408 ... one step per period, reaching 0x464 after 25 boundaries. duty_upd pulses once per step, then stays low.
- Transfer cmd=-1024 from duty=0x464 -> duty decrements by 4 per period to 0x000 with no underflow or wrap. Then cmd=+1023 -> duty climbs to 0x7FF and stops.
- Drive ovr_I=1 only during counter<BLANK with duty=0x600 -> ovr_cnt stays 0 and there is no fault. Then drive ovr_I=1 at counter=200 for 8 consecutive periods -> fault=1 at the 8th boundary, duty=0x400 the next cycle, cmd_rdy=0.
- Over-current in 7 periods, then one clean period, then 7 more -> no fault, because ovr_cnt resets on the clean period.
- In FAULT, assert cmd_vld with cmd=+300 -> not accepted. Pulse clr_fault -> fault=0, cmd_rdy=1, duty remains 0x400 until a new command ramps it. Assert rst_n=0 mid-ramp -> duty=0x400 immediately.
